shift_in_frame: RTL and testbench
=================================

Name: shift_in_frame

Overview:
Parametrised serial-in, parallel-out deserializer. Successor to the single-shot shift-in register. It adds:
- programmable frame length;
- MSB- or LSB-first bit order;
- continuous back-to-back framing;
- a double-buffered output with a valid/ready handshake and a sticky overrun flag.

It sits between a serial receive front end (SPI/bit-bang style data) and a parallel word consumer.

Parameters:
- WIDTH, 32, maximum frame length in bits and width of dout.
- LEN_W, 6, width of the len port. Must satisfy 2**LEN_W > WIDTH.
- LSB_FIRST, 0, bit order. 0 = first received bit is the MSB of the frame; 1 = first received bit is bit 0.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset; asynchronous, active-high.
- enable  in  1  qualifies si. One bit is taken per clk edge with enable=1.
- si  in  1  serial data in.
- sync  in  1  synchronous frame restart. Discards any partial frame.
- len  in  LEN_W  frame length in bits. Legal range 1..WIDTH; 0 is treated as WIDTH; values above WIDTH are treated as WIDTH.
- dout  out  WIDTH  completed frame, right-aligned, unused upper bits zero.
- dout_valid  out  1  dout holds an unconsumed frame.
- dout_ready  in  1  consumer accepts dout when dout_valid=1.
- busy  out  1  a partial frame is in progress (bit counter nonzero).
- overrun  out  1  sticky: a completed frame was dropped.
- ovr_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (clr=1, asynchronous): shift register=0, bit counter=0, dout=0, dout_valid=0, overrun=0, busy=0. Reset mid-frame discards the partial frame and the held output word.
- Frame length latch: len is latched into len_q on the edge that takes the first bit of a frame (counter=0, enable=1). Changes to len mid-frame do not affect that frame.
- Shifting, per edge with enable=1 and sync=0:
  - MSB-first: sh <= {sh[WIDTH-2:0], si}.
  - LSB-first: sh <= {si, sh[WIDTH-1:1]}.
  - Counter increments.
- Frame completion: the enabled edge that takes bit number len_q (counter = len_q-1).
  - The assembled word, including the current bit, is formed. For LSB-first it is right-shifted by WIDTH-len_q so it is right-aligned.
  - Counter and shift register return to 0 on the same edge. The next enabled edge starts a new frame with no gap cycle.
- Output load/handshake:
  - On completion, if dout_valid=0, or dout_valid=1 and dout_ready=1 on that edge: dout <= word and dout_valid=1.
  - Otherwise the word is dropped, dout and dout_valid are unchanged, and overrun <= 1.
  - Latency: dout_valid is seen high directly after the edge that samples the last bit.
  - Without a completion, dout_valid=1 and dout_ready=1 clears dout_valid. dout holds its last value (not cleared).
  - dout_ready while dout_valid=0 is ignored.
- sync: has priority over enable. It clears the counter and shift register; the bit on si is not taken. It does not affect dout, dout_valid or overrun.
- overrun: cleared only by clr or ovr_clr. If ovr_clr and a new overrun occur on the same edge, overrun stays 1 (set wins).
- busy = (counter != 0), registered from the counter. It is 0 between frames and after the completing edge.
- enable=0: all state holds. The handshake still operates.
- Counter width LEN_W. It never exceeds WIDTH-1, so there is no wrap hazard.

Test Plan:
1. Bit-order cases:
   - MSB-first: WIDTH=8, len=8, enabled bits 1,0,1,1,0,0,1,0, dout_ready=0 → after the 8th edge dout=0xB2, dout_valid=1, busy=0.
   - LSB-first: same bits with LSB_FIRST=1 → dout=0x4D.
2. Short frame, back-to-back: WIDTH=8, len=4, MSB-first. Bits 1,1,0,1 then 0,1,1,0 with no gap, dout_ready=1 throughout → dout=0x0D, then dout=0x06. Each valid is high for one cycle; overrun=0.
3. Overrun: dout_ready=0, two complete len=8 frames 0xA5 then 0x3C → dout stays 0xA5, overrun=1. ovr_clr pulse → overrun=0, dout_valid still 1.
4. Simultaneous accept and complete: frame 0x11 held with dout_valid=1. dout_ready=1 on the edge completing frame 0x22 → dout=0x22, dout_valid=1, overrun=0.
5. Mid-frame events:
   - Enabled edges with enable toggling every other cycle → same result as scenario 1.
   - sync after 3 bits → busy=0; the next 8 bits yield a correct frame.
   - len changed from 8 to 4 mid-frame → that frame still completes at 8 bits.
6. Async clr mid-frame after 5 bits, with dout_valid=1 and overrun=1 → all outputs 0 immediately, without waiting for a clock edge. A following frame 0x5A is captured correctly.

Source files
------------

// File: rtl/shift_in_frame.sv
// Serial-in, parallel-out deserializer with programmable frame length, selectable bit order,
// back-to-back framing and a double-buffered valid/ready output with a sticky overrun flag.
module shift_in_frame #(
  parameter int WIDTH     = 32,
  parameter int LEN_W     = 6,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic             si,
  input  logic             sync,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  // Zero and oversize lengths both mean a full-width frame.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
    if (l == '0 || l > WIDTH_L) return WIDTH_L;
    return l;
  endfunction

  // LSB-first words build up from the top of the register and need right-aligning.
  function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] w,
                                                  input logic [LEN_W-1:0] n);
    if (LSB_FIRST != 0) return w >> (WIDTH_L - n);
    return w;
  endfunction

  logic [WIDTH-1:0] sh_p0;
  logic [LEN_W-1:0] cnt_p0;
  logic [LEN_W-1:0] len_p0;

  logic [WIDTH-1:0] sh_nxt;
  logic [LEN_W-1:0] len_use;
  logic             take;
  logic             last;
  logic             drop;

  always_comb begin
    take    = enable & ~sync;
    len_use = (cnt_p0 == '0) ? sat_len(len) : len_p0;
    last    = take && (cnt_p0 == len_use - 1'b1);
    drop    = last && dout_valid && !dout_ready;
    if (LSB_FIRST != 0) sh_nxt = {si, sh_p0[WIDTH-1:1]};
    else                sh_nxt = {sh_p0[WIDTH-2:0], si};
  end

  // Stage p0: shift register, bit counter and double-buffered output word
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sh_p0      <= '0;
      cnt_p0     <= '0;
      len_p0     <= '0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (sync) begin
        sh_p0  <= '0;
        cnt_p0 <= '0;
        busy   <= 1'b0;
      end else if (enable) begin
        if (cnt_p0 == '0) len_p0 <= sat_len(len);
        if (last) begin
          sh_p0  <= '0;
          cnt_p0 <= '0;
          busy   <= 1'b0;
        end else begin
          sh_p0  <= sh_nxt;
          cnt_p0 <= cnt_p0 + 1'b1;
          busy   <= 1'b1;
        end
      end

      if (last && !drop) begin
        dout       <= align_word(sh_nxt, len_use);
        dout_valid <= 1'b1;
      end else if (!last && dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_in_frame.sv
// Bench for shift_in_frame: MSB-first and LSB-first instances side by side, a vector table
// for frame lengths/orders, plus hand sequences for overrun, sync, len change and async clear.
module tb_shift_in_frame;

  logic       clk = 1'b0;
  logic       clr, enable, si, sync, dout_ready, ovr_clr;
  logic [3:0] len;
  logic [7:0] dout_m, dout_l;
  logic       dv_m, dv_l, busy_m, busy_l, ovr_m, ovr_l;

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  typedef struct {
    logic [3:0] len;
    int         n;
    logic [7:0] seq;
    logic [7:0] em;
    logic [7:0] el;
  } vec_t;

  vec_t tv[10];

  always #5 clk = ~clk;

  shift_in_frame #(.WIDTH(8), .LEN_W(4), .LSB_FIRST(0)) u_msb (
    .clk(clk), .clr(clr), .enable(enable), .si(si), .sync(sync), .len(len),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready), .busy(busy_m),
    .overrun(ovr_m), .ovr_clr(ovr_clr));

  shift_in_frame #(.WIDTH(8), .LEN_W(4), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .clr(clr), .enable(enable), .si(si), .sync(sync), .len(len),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready), .busy(busy_l),
    .overrun(ovr_l), .ovr_clr(ovr_clr));

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev_n(input logic [7:0] s, input int n);
    logic [7:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = s[n-1-i];
    return r;
  endfunction

  task automatic push(input logic [7:0] m, input logic [7:0] l);
    q_m.push_back(m);
    q_l.push_back(l);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First bit sent is seq[n-1]; with gaps, an idle cycle carrying a wrong si follows each bit.
  task automatic send_frame(input logic [7:0] seq, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      enable = 1'b1;
      si     = seq[i];
      step();
      if (gaps) begin
        enable = 1'b0;
        si     = ~seq[i];
        step();
      end
    end
    enable = 1'b0;
    si     = 1'b0;
  endtask

  // A word is consumed on the edge following a negedge that sees valid and ready together.
  always @(negedge clk) begin
    if (mon_on && dout_ready && dv_m) begin
      checks++;
      if (q_m.size() == 0) begin
        failures++;
        $display("FAIL sb_msb unexpected word actual=%02h expected=none", dout_m);
      end else chk8("sb_msb", dout_m, q_m.pop_front());
    end
    if (mon_on && dout_ready && dv_l) begin
      checks++;
      if (q_l.size() == 0) begin
        failures++;
        $display("FAIL sb_lsb unexpected word actual=%02h expected=none", dout_l);
      end else chk8("sb_lsb", dout_l, q_l.pop_front());
    end
  end

  initial begin
    tv[0] = '{4'd8,  8, 8'hB2, 8'hB2, 8'h4D};
    tv[1] = '{4'd4,  4, 8'h0D, 8'h0D, 8'h0B};
    tv[2] = '{4'd4,  4, 8'h06, 8'h06, 8'h06};
    tv[3] = '{4'd8,  8, 8'hA5, 8'hA5, 8'hA5};
    tv[4] = '{4'd8,  8, 8'h3C, 8'h3C, 8'h3C};
    tv[5] = '{4'd1,  1, 8'h01, 8'h01, 8'h01};
    tv[6] = '{4'd0,  8, 8'hC1, 8'hC1, 8'h83};
    tv[7] = '{4'd15, 8, 8'h0F, 8'h0F, 8'hF0};
    tv[8] = '{4'd3,  3, 8'h06, 8'h06, 8'h03};
    tv[9] = '{4'd5,  5, 8'h13, 8'h13, 8'h19};

    clr = 1'b1; enable = 1'b0; si = 1'b0; sync = 1'b0;
    dout_ready = 1'b0; ovr_clr = 1'b0; len = 4'd8;
    step();
    step();
    chk8("rst_dout_m", dout_m, 8'h00);
    chk8("rst_dout_l", dout_l, 8'h00);
    chk1("rst_valid", dv_m, 1'b0);
    chk1("rst_busy", busy_m, 1'b0);
    chk1("rst_overrun", ovr_m, 1'b0);
    clr    = 1'b0;
    mon_on = 1'b1;

    // Back-to-back frames with the consumer always ready
    dout_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      len = tv[k].len;
      push(tv[k].em, tv[k].el);
      send_frame(tv[k].seq, tv[k].n, 1'b0);
      chk1($sformatf("tv%0d_valid", k), dv_m, 1'b1);
      chk1($sformatf("tv%0d_busy", k), busy_m, 1'b0);
      chk8($sformatf("tv%0d_dout_m", k), dout_m, tv[k].em);
      chk8($sformatf("tv%0d_dout_l", k), dout_l, tv[k].el);
      chk1($sformatf("tv%0d_overrun", k), ovr_m, 1'b0);
    end
    step();
    chk1("valid_one_cycle", dv_m, 1'b0);

    // Overrun: second frame dropped while the first is held
    len = 4'd8;
    dout_ready = 1'b0;
    push(8'hA5, 8'hA5);
    send_frame(8'hA5, 8, 1'b0);
    send_frame(8'h3C, 8, 1'b0);
    chk8("ovr_dout_held", dout_m, 8'hA5);
    chk1("ovr_valid", dv_m, 1'b1);
    chk1("ovr_set_m", ovr_m, 1'b1);
    chk1("ovr_set_l", ovr_l, 1'b1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk1("ovr_cleared", ovr_m, 1'b0);
    chk1("ovr_clr_valid_kept", dv_m, 1'b1);
    ovr_clr = 1'b1;
    send_frame(8'h3C, 8, 1'b0);
    chk1("ovr_set_wins", ovr_m, 1'b1);
    step();
    ovr_clr = 1'b0;
    chk1("ovr_cleared2", ovr_m, 1'b0);

    // Accept of the held word on the same edge that completes the next frame
    push(8'h22, rev_n(8'h22, 8));
    send_frame(8'h11, 7, 1'b0);
    dout_ready = 1'b1;
    enable = 1'b1;
    si = 1'b0;
    step();
    enable = 1'b0;
    chk8("acc_cmp_dout_m", dout_m, 8'h22);
    chk8("acc_cmp_dout_l", dout_l, 8'h44);
    chk1("acc_cmp_valid", dv_m, 1'b1);
    chk1("acc_cmp_overrun", ovr_m, 1'b0);
    step();
    chk1("acc_cmp_drained", dv_m, 1'b0);

    // Enable toggling between bits
    push(8'hB2, 8'h4D);
    send_frame(8'hB2, 8, 1'b1);

    // sync discards a partial frame
    send_frame(8'h05, 3, 1'b0);
    chk1("sync_pre_busy", busy_m, 1'b1);
    sync = 1'b1; enable = 1'b1; si = 1'b1;
    step();
    sync = 1'b0; enable = 1'b0;
    chk1("sync_busy", busy_m, 1'b0);
    chk1("sync_no_valid", dv_m, 1'b0);
    push(8'h96, rev_n(8'h96, 8));
    send_frame(8'h96, 8, 1'b0);
    chk8("sync_frame", dout_m, 8'h96);
    chk1("sync_frame_valid", dv_m, 1'b1);

    // len change mid-frame does not shorten the frame in progress
    len = 4'd8;
    push(8'hC3, rev_n(8'hC3, 8));
    send_frame(8'h0C, 4, 1'b0);
    len = 4'd4;
    chk1("lenchg_busy", busy_m, 1'b1);
    send_frame(8'h03, 4, 1'b0);
    chk1("lenchg_valid", dv_m, 1'b1);
    chk1("lenchg_busy_end", busy_m, 1'b0);
    chk8("lenchg_dout", dout_m, 8'hC3);
    len = 4'd8;
    step();

    // Asynchronous clear mid-frame with a held word and overrun pending
    dout_ready = 1'b0;
    send_frame(8'h11, 8, 1'b0);
    send_frame(8'h33, 8, 1'b0);
    send_frame(8'h1F, 5, 1'b0);
    chk1("aclr_pre_busy", busy_m, 1'b1);
    chk1("aclr_pre_ovr", ovr_m, 1'b1);
    #2;
    clr = 1'b1;
    #1;
    chk8("aclr_dout_m", dout_m, 8'h00);
    chk8("aclr_dout_l", dout_l, 8'h00);
    chk1("aclr_valid", dv_m, 1'b0);
    chk1("aclr_busy", busy_m, 1'b0);
    chk1("aclr_overrun", ovr_m, 1'b0);
    clr = 1'b0;
    step();
    dout_ready = 1'b1;
    push(8'h5A, rev_n(8'h5A, 8));
    send_frame(8'h5A, 8, 1'b0);
    chk8("aclr_next_m", dout_m, 8'h5A);
    chk8("aclr_next_l", dout_l, 8'h5A);
    chk1("aclr_next_valid", dv_m, 1'b1);
    step();
    step();
    chk1("sb_msb_empty", q_m.size() == 0, 1'b1);
    chk1("sb_lsb_empty", q_l.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
